// File: rtl/mem_responder_if.sv
// Request/response bus between the fetch engine and mem_responder. The host
// preload port travels with it so a single handle carries all traffic.
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  h_wr_en;
  logic [ADDR_WIDTH-1:0] h_wr_addr;
  logic [DATA_WIDTH-1:0] h_wr_data;
  logic                  m_req_vld;
  logic                  m_req_rdy;
  logic [ADDR_WIDTH-1:0] m_req_addr;
  logic                  m_rsp_vld;
  logic [DATA_WIDTH-1:0] m_rsp_data;

  modport master (
    output h_wr_en, h_wr_addr, h_wr_data, m_req_vld, m_req_addr,
    input  m_req_rdy, m_rsp_vld, m_rsp_data
  );

  modport slave (
    input  h_wr_en, h_wr_addr, h_wr_data, m_req_vld, m_req_addr,
    output m_req_rdy, m_rsp_vld, m_rsp_data
  );
endinterface

// File: rtl/mem_responder.sv
// On-chip word memory answering fetch reads after a fixed latency, in order.
// Optional MEM_RSP_STALL_EN adds LFSR-driven pseudo-random request stalls.
module mem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int MEM_DEPTH       = 256,
  parameter int RD_LATENCY      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_responder_if.slave   bus,
  output logic [3:0]       outstanding,
  output logic             err_oob,
  input  logic             err_clr
);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int STAGES = RD_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0]          MAX_L   = 4'(MAX_OUTSTANDING);

  logic [DATA_WIDTH-1:0]             mem_q [MEM_DEPTH];
  logic [STAGES:0]                   vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0]   dat_pipe;
  logic [3:0]                        outstanding_q, outstanding_d;
  logic                              err_q, err_d;

  logic                  wr_in_rng, rd_in_rng, wr, acc, rsp, stall, slot_free;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_in_rng = {1'b0, bus.h_wr_addr}  < DEPTH_L;
  assign rd_in_rng = {1'b0, bus.m_req_addr} < DEPTH_L;
  assign wr        = bus.h_wr_en && wr_in_rng;
  assign rd_word   = rd_in_rng ? mem_q[bus.m_req_addr[IDX_W-1:0]] : '0;

  // A beat leaving the pipe this cycle frees its slot for a same-cycle accept.
  assign rsp       = vld_pipe[STAGES];
  assign slot_free = (outstanding_q - {3'b0, rsp}) < MAX_L;

`ifdef MEM_RSP_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Host writes own the array port, so they stall the request side.
  assign bus.m_req_rdy = rst_n && !bus.h_wr_en && !stall && slot_free;
  assign acc           = bus.m_req_vld && bus.m_req_rdy;

  always_ff @(posedge clk) begin
    if (wr) mem_q[bus.h_wr_addr[IDX_W-1:0]] <= bus.h_wr_data;
  end

  // Each data stage only loads behind a valid beat, so the last stage holds
  // the most recent response while the output is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= acc;
      if (acc) dat_pipe[0] <= rd_word;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + {3'b0, acc} - {3'b0, rsp};
    err_d         = err_q;
    if ((acc && !rd_in_rng) || (bus.h_wr_en && !wr_in_rng)) err_d = 1'b1;
    else if (err_clr)                                       err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign bus.m_rsp_vld  = rsp;
  assign bus.m_rsp_data = dat_pipe[STAGES];
  assign outstanding    = outstanding_q;
  assign err_oob        = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Random + directed bench for mem_responder against a queue-based model.
module tb_mem_responder;
  localparam int DW = 32, AW = 10, DEPTH = 256, LAT = 2, MAXO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();
  logic [3:0] outst, outst2;
  logic       err_oob, err_oob2, err_clr, err_clr2;

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
                  .RD_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .outstanding(outst),
    .err_oob(err_oob), .err_clr(err_clr));

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
                  .RD_LATENCY(3), .MAX_OUTSTANDING(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .outstanding(outst2),
    .err_oob(err_oob2), .err_clr(err_clr2));

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model: word array, in-order queue of (due cycle, data), sticky error.
  logic [DW-1:0] mmem [DEPTH];
  int            due_q[$];
  logic [DW-1:0] dat_q[$];
  int            cyc = 0;
  logic [DW-1:0] last = '0;
  bit            merr = 1'b0;
  int            stall_n = 0, elig_n = 0;

  task automatic drive(bit v, logic [AW-1:0] a, bit w, logic [AW-1:0] wa,
                       logic [DW-1:0] wd, bit clr);
    bus.m_req_vld = v;  bus.m_req_addr = a;
    bus.h_wr_en   = w;  bus.h_wr_addr  = wa; bus.h_wr_data = wd;
    err_clr       = clr;
  endtask

  task automatic idle(int n);
    drive(0, '0, 0, '0, '0, 0);
    repeat (n) cycle();
  endtask

  task automatic rst_chk(string t);
    chk({t, "_rdy"}, {31'b0, bus.m_req_rdy}, 0);
    chk({t, "_vld"}, {31'b0, bus.m_rsp_vld}, 0);
    chk({t, "_data"}, bus.m_rsp_data, 0);
    chk({t, "_outst"}, {28'b0, outst}, 0);
    chk({t, "_err"}, {31'b0, err_oob}, 0);
  endtask

  task automatic model_reset();
    due_q.delete(); dat_q.delete();
    last = '0; merr = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    bit exp_rsp, exp_rdy, acc;
    logic [AW-1:0] ra, wa;
    @(negedge clk);
    exp_rsp = (due_q.size() > 0) && (due_q[0] == cyc);
    exp_rdy = rst_n && !bus.h_wr_en && ((due_q.size() - int'(exp_rsp)) < MAXO);
`ifdef MEM_RSP_STALL_EN
    if (exp_rdy) begin
      elig_n++;
      if (!bus.m_req_rdy) stall_n++;
    end else chk("rdy_low", {31'b0, bus.m_req_rdy}, 0);
`else
    chk("rdy", {31'b0, bus.m_req_rdy}, {31'b0, exp_rdy});
`endif
    chk("rsp_vld", {31'b0, bus.m_rsp_vld}, {31'b0, exp_rsp});
    if (exp_rsp) last = dat_q[0];
    chk("rsp_data", bus.m_rsp_data, last);
    chk("outstanding", {28'b0, outst}, due_q.size());
    chk("err_oob", {31'b0, err_oob}, {31'b0, merr});
    acc = bus.m_req_vld && bus.m_req_rdy;
    @(posedge clk);
    ra = bus.m_req_addr; wa = bus.h_wr_addr;
    if (exp_rsp) begin void'(due_q.pop_front()); void'(dat_q.pop_front()); end
    if (acc) begin
      due_q.push_back(cyc + LAT);
      dat_q.push_back((ra < DEPTH) ? mmem[ra[7:0]] : '0);
    end
    if (bus.h_wr_en && wa < DEPTH) mmem[wa[7:0]] = bus.h_wr_data;
    if ((acc && ra >= DEPTH) || (bus.h_wr_en && wa >= DEPTH)) merr = 1'b1;
    else if (err_clr) merr = 1'b0;
    cyc++;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] init4 [4];
    logic [AW-1:0] a, wa;
    bit v, w;
    init4[0] = 32'h11; init4[1] = 32'h22; init4[2] = 32'h33; init4[3] = 32'h44;
    drive(0, '0, 0, '0, '0, 0);
    bus2.h_wr_en = 0; bus2.h_wr_addr = '0; bus2.h_wr_data = '0;
    bus2.m_req_vld = 0; bus2.m_req_addr = '0; err_clr2 = 0;

    repeat (2) @(posedge clk);
    #1; rst_chk("reset");
    rst_n = 1'b1;
    model_reset();

    // Single-slot, latency-3 instance: rdy 1,0,0 and one beat every 3 cycles.
    bus2.h_wr_en = 1; bus2.h_wr_addr = 10'd7; bus2.h_wr_data = 32'h5A;
    @(posedge clk); #1;
    bus2.h_wr_en = 0; bus2.m_req_vld = 1; bus2.m_req_addr = 10'd7;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
`ifndef MEM_RSP_STALL_EN
      chk("lat3_rdy", {31'b0, bus2.m_req_rdy}, {31'b0, (c % 3) == 0});
      chk("lat3_vld", {31'b0, bus2.m_rsp_vld}, {31'b0, (c >= 3) && (c % 3) == 0});
`endif
      if (bus2.m_rsp_vld) chk("lat3_data", bus2.m_rsp_data, 32'h5A);
      chk("lat3_outst_max", {31'b0, outst2 <= 4'd1}, 1);
      @(posedge clk); #1;
    end
    bus2.m_req_vld = 0;

    // Preload every word; requests during writes must not be accepted.
    for (int i = 0; i < DEPTH; i++) begin
      drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, 255)), 1, AW'(i),
            (i < 4) ? init4[i] : $urandom, 0);
      cycle();
    end

    for (int i = 0; i < 4; i++) begin
      drive(1, AW'(i), 0, '0, '0, 0);
      cycle();
    end
    idle(3);

    // Write collides with a held request; next-cycle accept sees the new word.
    drive(1, 10'd5, 1, 10'd5, 32'h9A, 0); cycle();
    drive(1, 10'd5, 0, '0, '0, 0);        cycle();
    idle(3);

    drive(1, 10'd300, 0, '0, '0, 0); cycle();
    idle(3);
    drive(0, '0, 0, '0, '0, 1); cycle();
    idle(2);
    drive(0, '0, 1, 10'd700, 32'hDEAD, 0); cycle();
    drive(0, '0, 0, '0, '0, 1); cycle();
    idle(2);

    for (int i = 0; i < 1000; i++) begin
      v  = $urandom_range(0, 99) < 75;
      a  = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(256, 1023)) : AW'($urandom_range(0, 255));
      w  = $urandom_range(0, 99) < 12;
      wa = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(256, 1023)) : AW'($urandom_range(0, 255));
      drive(v, a, w, wa, $urandom, $urandom_range(0, 99) < 5);
      cycle();
    end
    idle(4);

    // Reset with two reads in flight: outputs clear at once, no late beats.
    drive(1, 10'd1, 0, '0, '0, 0); cycle();
    drive(1, 10'd2, 0, '0, '0, 0); cycle();
    drive(0, '0, 0, '0, '0, 0);
    rst_n = 1'b0;
    #1; rst_chk("mid_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    for (int i = 0; i < 4; i++) begin
      drive(1, AW'(i), 0, '0, '0, 0);
      cycle();
    end
    idle(4);

`ifdef MEM_RSP_STALL_EN
    chk("stall_frac_in_20_30",
        {31'b0, (stall_n * 100 >= elig_n * 20) && (stall_n * 100 <= elig_n * 30)}, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
On-chip word memory that serves the fetch engine's memory request/response interface (m_req_*/m_rsp_*) inside the GPU.
- Host preloads matrix operands through a simple write port.
- Fetch engine issues read requests with a valid/ready handshake; each accepted request returns one data beat after a fixed, parameterised latency, in order.
- The response channel has no ready, so the block never backpressures a response; flow control lives entirely on m_req_rdy.

Parameters:
DATA_WIDTH, bronco_params::DATA_WIDTH, width of a memory word and of m_rsp_data
ADDR_WIDTH, bronco_params::ADDR_WIDTH, width of request and host-write addresses
MEM_DEPTH, 256, number of words implemented (legal addresses 0..MEM_DEPTH-1); must be ≤ 2**ADDR_WIDTH
RD_LATENCY, 2, cycles from request acceptance to response valid; legal range 1..8
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..RD_LATENCY

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
h_wr_en  input  1  host write strobe, one word per cycle
h_wr_addr  input  ADDR_WIDTH  host write address
h_wr_data  input  DATA_WIDTH  host write data
m_req_vld  input  1  read request valid
m_req_rdy  output  1  request can be accepted this cycle
m_req_addr  input  ADDR_WIDTH  read address
m_rsp_vld  output  1  response beat valid, single cycle, no ready
m_rsp_data  output  DATA_WIDTH  response data
outstanding  output  4  accepted requests not yet answered
err_oob  output  1  sticky: a read or write targeted an address ≥ MEM_DEPTH
err_clr  input  1  synchronous clear of err_oob

Behaviour:
- Reset (rst_n low, async): m_req_rdy=0, m_rsp_vld=0, m_rsp_data=0, outstanding=0, err_oob=0, latency pipe cleared. Memory contents are not reset.
- m_req_rdy is combinational: !h_wr_en && (outstanding < MAX_OUTSTANDING). It goes to 1 on the first cycle after reset deassertion.
- Accept: m_req_vld && m_req_rdy at a rising edge. The array is read at that edge and the word, or 0 if out of range, enters stage 1 of a RD_LATENCY-deep valid/data shift pipe.
- Response: m_rsp_vld=1 with m_rsp_data exactly RD_LATENCY cycles after the accept edge. This holds regardless of m_req_vld and for back-to-back accepts. Responses are strictly in order.
- When m_rsp_vld=0, m_rsp_data holds its last value.
- Host write: writes the array at the edge when h_wr_en=1 and the address is in range. Host writes have priority: the request port is stalled that cycle.
- Read-after-write: a request accepted in the cycle after a write returns the new data.
- Data returned is the array value at the accept edge; later host writes do not alter in-flight responses.
- outstanding: +1 on accept, −1 on response issue, unchanged when both occur in the same cycle. Never exceeds MAX_OUTSTANDING.
- With MAX_OUTSTANDING < RD_LATENCY, throughput is MAX_OUTSTANDING requests per RD_LATENCY cycles. A response-issue cycle frees a slot combinationally, so a new accept is allowed in that same cycle.
- Out-of-range addresses:
  - Read ≥ MEM_DEPTH: accepted normally, returns 0, sets err_oob at the accept edge.
  - Host write ≥ MEM_DEPTH: dropped, sets err_oob.
- err_clr clears err_oob. If a new error and err_clr coincide, the set wins.
- Reset mid-operation: all in-flight responses are discarded and no m_rsp_vld is emitted for them after reset release.
- m_req_addr is ignored when the request is not accepted. m_req_vld may drop without a handshake; nothing is recorded.

Optional Feature:
MEM_RSP_STALL_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) advances every cycle. m_req_rdy is additionally gated low whenever LFSR[1:0]==2'b00 (~25% stall cycles), to stress fetch-engine backpressure. All other rules are unchanged.
- Not defined: no LFSR logic is instantiated and m_req_rdy follows the base equation only.

Test Plan:
1. Host writes addr 0..3 = 8'h11,8'h22,8'h33,8'h44, then back-to-back reads 0..3 with RD_LATENCY=2, MAX_OUTSTANDING=2 -> m_rsp_data 11,22,33,44 in order, each exactly 2 cycles after its accept. outstanding never exceeds 2 and m_req_rdy never drops.
2. MAX_OUTSTANDING=1, RD_LATENCY=3, m_req_vld held high -> m_req_rdy pattern 1,0,0 repeating. One response every 3 cycles.
3. Request held at addr 5 while h_wr_en=1 writes addr 5 = 8'h9A -> no accept that cycle. Accept next cycle returns 8'h9A.
4. Read addr 300 (MEM_DEPTH=256) -> m_rsp_data=0 after RD_LATENCY and err_oob=1 from the cycle after accept. err_clr pulse -> err_oob=0.
5. Two requests in flight, rst_n pulsed low for 1 cycle -> all outputs 0 immediately and no m_rsp_vld after release. Memory still holds the earlier writes on re-read.
6. With MEM_RSP_STALL_EN, 1000 random reads -> every response matches the memory model in order, and the stall fraction is 20–30%.
